data_mem_ext: RTL and testbench

//  Parametrised successor of the 8x8 CPU data memory: DEPTH x DATA_W register-file RAM, one masked write port,
//  two asynchronous read ports, plus a hardware clear engine that zeroes the array without a reset.

---
 rtl/data_mem_ext.sv | 119 +++++++++++
 tb/tb_data_mem_ext.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ext.sv
// Data memory: DEPTH x DATA_W register file with lane-masked write,
// two async read ports and a hardware clear engine. State moves on negedge.
module data_mem_ext #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8,
   parameter int LANE_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enW,
   input  logic [DATA_W/LANE_W-1:0]   wmask,
   input  logic [ADDR_W-1:0]          addrW,
   input  logic [DATA_W-1:0]          dataW,
   input  logic [ADDR_W-1:0]          addrR0,
   output logic [DATA_W-1:0]          readD0,
   input  logic [ADDR_W-1:0]          addrR1,
   output logic [DATA_W-1:0]          readD1,
   input  logic                       clr_req,
   output logic                       busy,
   output logic                       clr_done,
   output logic                       wr_err
);

   localparam int NL = DATA_W / LANE_W;
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_clr_done;
   logic              r_wr_err;

   logic w_clearing;
   logic w_wr_inrange;
   logic w_wr_go;
   logic w_wr_drop;
   logic w_rd0_ok;
   logic w_rd1_ok;

   assign w_clearing   = (r_state == S_CLEAR);
   assign w_wr_inrange = ({1'b0, addrW} < LP_DEPTH);
   assign w_wr_go      = enW & w_wr_inrange & ~w_clearing;
   assign w_wr_drop    = enW & (~w_wr_inrange | w_clearing);

   assign w_rd0_ok = ({1'b0, addrR0} < LP_DEPTH);
   assign w_rd1_ok = ({1'b0, addrR1} < LP_DEPTH);

   assign readD0 = w_rd0_ok ? r_mem[addrR0] : '0;
   assign readD1 = w_rd1_ok ? r_mem[addrR1] : '0;

   assign busy     = w_clearing;
   assign clr_done = r_clr_done;
   assign wr_err   = r_wr_err;

   // Array: clear engine zeroes one word per edge, otherwise lane-masked write
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_clearing) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_go) begin
         for (int l = 0; l < NL; l++) begin
            if (wmask[l]) begin
               r_mem[addrW][l*LANE_W +: LANE_W] <=
                  dataW[l*LANE_W +: LANE_W];
            end
         end
      end
   end

   // Clear FSM: walk ptr 0..DEPTH-1, then pulse clr_done on the way out
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_clr_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (clr_req) begin
                  r_state <= S_CLEAR;
                  r_ptr   <= '0;
               end
            end
            S_CLEAR: begin
               if (r_ptr == LP_LAST) begin
                  r_state    <= S_IDLE;
                  r_ptr      <= '0;
                  r_clr_done <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + ADDR_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   // Write error flag: one cycle high after a dropped write
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= w_wr_drop;
      end
   end

endmodule

// File: tb/tb_data_mem_ext.sv
// Bench for data_mem_ext: directed stimulus pushes expectations into a
// queue, a monitor process pops and compares at each sample strobe.
module tb_data_mem_ext;

   typedef struct {
      int         kind;
      logic [7:0] val;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   event chk_ev;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enW = 1'b0;
   logic [1:0] wmask = 2'b00;
   logic [2:0] addrW = '0;
   logic [7:0] dataW = '0;
   logic [2:0] addrR0 = '0;
   logic [2:0] addrR1 = '0;
   logic       clr_req = 1'b0;
   logic [7:0] readD0, readD1;
   logic       busy, clr_done, wr_err;

   logic       enW6 = 1'b0;
   logic [2:0] addrW6 = '0;
   logic [7:0] dataW6 = '0;
   logic [2:0] addrR6 = '0;
   logic [7:0] readD0_6, readD1_6;
   logic       busy6, clr_done6, wr_err6;

   always #20 clk = ~clk;

   data_mem_ext u_dut (
      .clk(clk), .rst_n(rst_n), .enW(enW), .wmask(wmask),
      .addrW(addrW), .dataW(dataW),
      .addrR0(addrR0), .readD0(readD0),
      .addrR1(addrR1), .readD1(readD1),
      .clr_req(clr_req), .busy(busy),
      .clr_done(clr_done), .wr_err(wr_err)
   );

   data_mem_ext #(.DEPTH(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .enW(enW6), .wmask(2'b11),
      .addrW(addrW6), .dataW(dataW6),
      .addrR0(addrR6), .readD0(readD0_6),
      .addrR1(addrR6), .readD1(readD1_6),
      .clr_req(1'b0), .busy(busy6),
      .clr_done(clr_done6), .wr_err(wr_err6)
   );

   // Monitor: drain the expectation queue on every sample strobe
   initial begin
      exp_t       e;
      logic [7:0] act;
      string      nm;
      forever begin
         @(chk_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
               0: begin act = readD0;           nm = "readD0";   end
               1: begin act = readD1;           nm = "readD1";   end
               2: begin act = {7'd0, busy};     nm = "busy";     end
               3: begin act = {7'd0, clr_done}; nm = "clr_done"; end
               4: begin act = {7'd0, wr_err};   nm = "wr_err";   end
               5: begin act = readD0_6;         nm = "d6_readD0"; end
               6: begin act = readD1_6;         nm = "d6_readD1"; end
               default: begin act = {7'd0, wr_err6}; nm = "d6_wr_err"; end
            endcase
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s tag=%0d actual=%h required=%h",
                        nm, e.tag, act, e.val);
            end
         end
      end
   end

   task automatic chk(input int k, input logic [7:0] v, input int t);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.tag  = t;
      q.push_back(e);
   endtask

   task automatic sample();
      #1;
      ->chk_ev;
      #1;
   endtask

   task automatic edge_();
      @(negedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] a0, input logic [7:0] v0,
                     input logic [2:0] a1, input logic [7:0] v1,
                     input int t);
      addrR0 = a0;
      addrR1 = a1;
      chk(0, v0, t);
      chk(1, v1, t);
      sample();
   endtask

   task automatic flags(input logic b, input logic d, input logic e,
                        input int t);
      chk(2, {7'd0, b}, t);
      chk(3, {7'd0, d}, t);
      chk(4, {7'd0, e}, t);
      sample();
   endtask

   task automatic do_wr(input logic [2:0] a, input logic [7:0] d,
                        input logic [1:0] m);
      enW   = 1'b1;
      addrW = a;
      dataW = d;
      wmask = m;
      edge_();
      enW   = 1'b0;
   endtask

   initial begin
      #50;
      rst_n = 1'b1;
      edge_();

      // 1: reset contents and flags
      for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 3'(7 - i), 8'h00, 100 + i);
      flags(0, 0, 0, 110);

      // 2: masked write merges lanes
      do_wr(3'd3, 8'hA5, 2'b11);
      rd(3'd3, 8'hA5, 3'd3, 8'hA5, 200);
      do_wr(3'd3, 8'h3C, 2'b01);
      rd(3'd3, 8'hAC, 3'd2, 8'h00, 201);
      flags(0, 0, 0, 202);
      do_wr(3'd3, 8'hFF, 2'b00);
      rd(3'd3, 8'hAC, 3'd3, 8'hAC, 203);
      flags(0, 0, 0, 204);

      // 3: fill then full clear
      for (int n = 0; n < 8; n++) do_wr(3'(n), 8'(8'h11 * n), 2'b11);
      rd(3'd7, 8'h77, 3'd1, 8'h11, 300);
      clr_req = 1'b1;
      edge_();
      clr_req = 1'b0;
      flags(1, 0, 0, 301);
      for (int k = 0; k < 4; k++) begin
         edge_();
         flags(1, 0, 0, 310 + k);
      end
      for (int i = 0; i < 4; i++)
         rd(3'(i), 8'h00, 3'(i + 4), 8'(8'h11 * (i + 4)), 320 + i);
      for (int k = 0; k < 3; k++) begin
         edge_();
         flags(1, 0, 0, 330 + k);
      end
      edge_();
      flags(0, 1, 0, 340);
      edge_();
      flags(0, 0, 0, 341);
      for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 3'(7 - i), 8'h00, 350 + i);

      // 4a: write during clear is dropped
      do_wr(3'd2, 8'h22, 2'b11);
      clr_req = 1'b1;
      edge_();
      clr_req = 1'b0;
      do_wr(3'd2, 8'h99, 2'b11);
      flags(1, 0, 1, 400);
      rd(3'd2, 8'h22, 3'd0, 8'h00, 401);
      for (int k = 0; k < 6; k++) begin
         edge_();
         flags(1, 0, 0, 410 + k);
      end
      edge_();
      flags(0, 1, 0, 420);
      rd(3'd2, 8'h00, 3'd7, 8'h00, 421);

      // 5: write on the clr_req edge lands, then is cleared
      do_wr(3'd1, 8'h5A, 2'b11);
      clr_req = 1'b1;
      do_wr(3'd0, 8'hFF, 2'b11);
      clr_req = 1'b0;
      rd(3'd0, 8'hFF, 3'd1, 8'h5A, 500);
      flags(1, 0, 0, 501);
      edge_();
      rd(3'd0, 8'h00, 3'd1, 8'h5A, 502);
      for (int k = 0; k < 6; k++) edge_();
      flags(1, 0, 0, 503);
      edge_();
      flags(0, 1, 0, 504);
      rd(3'd1, 8'h00, 3'd0, 8'h00, 505);

      // 6: reset in the middle of a clear
      do_wr(3'd4, 8'h44, 2'b11);
      do_wr(3'd6, 8'h66, 2'b11);
      clr_req = 1'b1;
      edge_();
      clr_req = 1'b0;
      for (int k = 0; k < 3; k++) edge_();
      rd(3'd4, 8'h44, 3'd6, 8'h66, 600);
      #5;
      rst_n = 1'b0;
      flags(0, 0, 0, 601);
      for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 3'(7 - i), 8'h00, 610 + i);
      for (int k = 0; k < 3; k++) begin
         edge_();
         flags(0, 0, 0, 620 + k);
      end
      #5;
      rst_n = 1'b1;
      edge_();
      do_wr(3'd5, 8'h77, 2'b11);
      rd(3'd5, 8'h77, 3'd4, 8'h00, 630);
      flags(0, 0, 0, 631);

      // 4b: DEPTH=6 build drops out-of-range writes
      enW6   = 1'b1;
      addrW6 = 3'd7;
      dataW6 = 8'hAB;
      edge_();
      enW6   = 1'b0;
      addrR6 = 3'd7;
      chk(7, 8'h01, 700);
      chk(5, 8'h00, 701);
      chk(6, 8'h00, 702);
      sample();
      enW6   = 1'b1;
      addrW6 = 3'd5;
      dataW6 = 8'h5C;
      edge_();
      enW6   = 1'b0;
      addrR6 = 3'd5;
      chk(7, 8'h00, 703);
      chk(5, 8'h5C, 704);
      sample();
      addrR6 = 3'd6;
      chk(5, 8'h00, 705);
      sample();

      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
